// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: ALU opcodes, FSM states,
// instruction fields and datapath mux selects.
package mips_pkg;

    localparam logic [3:0] ALU_SLL = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SRL = 4'b0011;
    localparam logic [3:0] ALU_SRA = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EXEC   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_I_EXEC   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [1:0] SRC_A_PC = 2'b00;
    localparam logic [1:0] SRC_A_RS = 2'b01;
    localparam logic [1:0] SRC_A_RT = 2'b10;

    localparam logic [2:0] SRC_B_RT      = 3'b000;
    localparam logic [2:0] SRC_B_FOUR    = 3'b001;
    localparam logic [2:0] SRC_B_SIMM    = 3'b010;
    localparam logic [2:0] SRC_B_SIMM_SH = 3'b011;
    localparam logic [2:0] SRC_B_ZIMM    = 3'b100;
    localparam logic [2:0] SRC_B_SHAMT   = 3'b101;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_funct_dec.sv
// R-type funct decoder: ALU opcode, legality and whether the op is a shift
// (shifts take rt on in1 and shamt on in2).
module alu_funct_dec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       legal,
    output logic       is_shift
);

    always_comb begin
        alu_op   = ALU_ADD;
        legal    = 1'b1;
        is_shift = 1'b0;
        case (funct)
            FN_ADD: alu_op = ALU_ADD;
            FN_SUB: alu_op = ALU_SUB;
            FN_AND: alu_op = ALU_AND;
            FN_OR:  alu_op = ALU_OR;
            FN_XOR: alu_op = ALU_XOR;
            FN_SLL: begin alu_op = ALU_SLL; is_shift = 1'b1; end
            FN_SRL: begin alu_op = ALU_SRL; is_shift = 1'b1; end
            FN_SRA: begin alu_op = ALU_SRA; is_shift = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Outputs are decoded combinationally from the state
// (plus opcode/funct/z_flag/mem_ready); write-type enables are masked during reset.
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       z_flag,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [3:0] alu_operation,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic [3:0] dbg_state
);

    state_t     state_q, state_d;
    logic [3:0] fn_op;
    logic       fn_legal, fn_shift;
    logic       mem_read_c, mem_write_c, ir_write_c, pc_en_c;
    logic       reg_write_c, done_c, illegal_c;

    alu_funct_dec u_funct_dec (
        .funct    (funct),
        .alu_op   (fn_op),
        .legal    (fn_legal),
        .is_shift (fn_shift)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        pc_en_c       = 1'b0;
        reg_write_c   = 1'b0;
        done_c        = 1'b0;
        illegal_c     = 1'b0;
        iord          = 1'b0;
        pc_source     = PC_SRC_ALU;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RT;
        alu_operation = ALU_SLL;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read_c    = 1'b1;
                alu_src_b     = SRC_B_FOUR;
                alu_operation = ALU_ADD;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_en_c    = 1'b1;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                alu_src_b     = SRC_B_SIMM_SH;
                alu_operation = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:             state_d = ST_MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = ST_I_EXEC;
                    OP_BEQ, OP_BNE:           state_d = ST_BRANCH;
                    OP_J:                     state_d = ST_JUMP;
                    OP_RTYPE: begin
                        if (fn_legal) state_d = ST_R_EXEC;
                        else begin
                            illegal_c = 1'b1;
                            state_d   = ST_FETCH;
                        end
                    end
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = ST_FETCH;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a     = SRC_A_RS;
                alu_src_b     = SRC_B_SIMM;
                alu_operation = ALU_ADD;
                state_d       = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_read_c = 1'b1;
                iord       = 1'b1;
                if (mem_ready) state_d = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                reg_write_c = 1'b1;
                mem_to_reg  = 1'b1;
                done_c      = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write_c = 1'b1;
                iord        = 1'b1;
                if (mem_ready) begin
                    done_c  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_R_EXEC: begin
                alu_src_a     = fn_shift ? SRC_A_RT : SRC_A_RS;
                alu_src_b     = fn_shift ? SRC_B_SHAMT : SRC_B_RT;
                alu_operation = fn_op;
                state_d       = ST_R_WB;
            end
            ST_R_WB: begin
                reg_write_c = 1'b1;
                reg_dst     = 1'b1;
                done_c      = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_I_EXEC: begin
                alu_src_a = SRC_A_RS;
                case (opcode)
                    OP_ANDI: begin alu_src_b = SRC_B_ZIMM; alu_operation = ALU_AND; end
                    OP_ORI:  begin alu_src_b = SRC_B_ZIMM; alu_operation = ALU_OR;  end
                    default: begin alu_src_b = SRC_B_SIMM; alu_operation = ALU_ADD; end
                endcase
                state_d = ST_I_WB;
            end
            ST_I_WB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = SRC_A_RS;
                alu_operation = ALU_SUB;
                pc_source     = PC_SRC_ALUOUT;
                pc_en_c       = (opcode == OP_BNE) ? !z_flag : z_flag;
                done_c        = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_source = PC_SRC_JUMP;
                pc_en_c   = 1'b1;
                done_c    = 1'b1;
                state_d   = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign mem_read      = mem_read_c & rst_n;
    assign mem_write     = mem_write_c & rst_n;
    assign ir_write      = ir_write_c & rst_n;
    assign pc_en         = pc_en_c & rst_n;
    assign reg_write     = reg_write_c & rst_n;
    assign instr_done    = done_c & rst_n;
    assign illegal_instr = illegal_c & rst_n;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed instruction sequence with per-cycle
// spot checks plus a retirement scoreboard keyed on instr_done/illegal_instr.
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    localparam int W = 13;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       z_flag, mem_ready;
    logic       mem_read, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_source, alu_src_a;
    logic [2:0] alu_src_b;
    logic [3:0] alu_operation, dbg_state;
    logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_instr;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_err    = 0;
    int cnt      = 0;

    mips_multicycle_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .z_flag        (z_flag),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_en         (pc_en),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_operation (alu_operation),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .instr_done    (instr_done),
        .illegal_instr (illegal_instr),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic ill, input logic [4:0] cyc, input logic rw,
                                        input logic mtr, input logic rd, input logic pce,
                                        input logic [1:0] pcs, input logic mw);
        return {ill, cyc, rw, mtr, rd, pce, pcs, mw};
    endfunction

    // ---------------- driver tasks ----------------
    // First cycle of an instruction: present IR fields, queue the expected retirement.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input logic push, input logic [W-1:0] exp);
        @(posedge clk); #1;
        opcode = op; funct = fn; z_flag = z; mem_ready = 1'b1;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
    endtask

    task automatic cyc(input logic mr);
        @(posedge clk); #1;
        mem_ready = mr;
        @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] act, exp;
        if (!rst_n) cnt = 0;
        else begin
            cnt++;
            if (instr_done || illegal_instr) begin
                check("done_and_illegal_exclusive", 16'(instr_done & illegal_instr), 16'(0));
                act = {illegal_instr, 5'(cnt), reg_write, mem_to_reg, reg_dst, pc_en,
                       pc_source, mem_write};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL retire_unexpected: got %0h expected none", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        n_err++;
                        $display("FAIL retire_record: got %0h expected %0h at %0t", act, exp, $time);
                    end
                end
                cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; opcode = OP_RTYPE; funct = FN_ADD; z_flag = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_state", 16'(dbg_state), 16'(ST_FETCH));
        check("rst_mem_read", 16'(mem_read), 16'(0));
        check("rst_ir_write", 16'(ir_write), 16'(0));
        check("rst_pc_en", 16'(pc_en), 16'(0));
        check("rst_src_b", 16'(alu_src_b), 16'(3'b001));
        check("rst_alu_op", 16'(alu_operation), 16'(4'b0010));

        // add: released straight into its FETCH cycle
        exp_q.push_back(mk(0, 4, 1, 0, 1, 0, 2'b00, 0));
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("add_fetch_state", 16'(dbg_state), 16'(ST_FETCH));
        check("add_fetch_ctrl", 16'({mem_read, ir_write, pc_en, iord}), 16'(4'b1110));
        cyc(1);
        check("add_decode_src_b", 16'(alu_src_b), 16'(3'b011));
        cyc(1);
        check("add_exec_alu", 16'({alu_operation, alu_src_a, alu_src_b}), 16'(9'b0010_01_000));
        cyc(1);
        check("add_wb", 16'({reg_write, reg_dst, mem_to_reg, instr_done}), 16'(4'b1101));

        // sll
        issue(OP_RTYPE, FN_SLL, 0, 1, mk(0, 4, 1, 0, 1, 0, 2'b00, 0));
        cyc(1); cyc(1);
        check("sll_exec", 16'({alu_operation, alu_src_a, alu_src_b}), 16'(9'b0000_10_101));
        cyc(1);

        // ori
        issue(OP_ORI, 6'h15, 0, 1, mk(0, 4, 1, 0, 0, 0, 2'b00, 0));
        cyc(1); cyc(1);
        check("ori_exec", 16'({alu_operation, alu_src_a, alu_src_b}), 16'(9'b0001_01_100));
        cyc(1);

        // beq taken / not taken, bne taken
        issue(OP_BEQ, 6'h00, 1, 1, mk(0, 3, 0, 0, 0, 1, 2'b01, 0));
        cyc(1); cyc(1);
        check("beq_z1", 16'({pc_en, pc_source, alu_operation}), 16'(7'b1_01_0110));
        issue(OP_BEQ, 6'h00, 0, 1, mk(0, 3, 0, 0, 0, 0, 2'b01, 0));
        cyc(1); cyc(1);
        check("beq_z0", 16'({pc_en, pc_source}), 16'(3'b0_01));
        issue(OP_BNE, 6'h00, 0, 1, mk(0, 3, 0, 0, 0, 1, 2'b01, 0));
        cyc(1); cyc(1);
        check("bne_z0", 16'({pc_en, pc_source}), 16'(3'b1_01));

        // j
        issue(OP_J, 6'h00, 0, 1, mk(0, 3, 0, 0, 0, 1, 2'b10, 0));
        cyc(1); cyc(1);
        check("j_state", 16'(dbg_state), 16'(ST_JUMP));

        // sw
        issue(OP_SW, 6'h00, 0, 1, mk(0, 4, 0, 0, 0, 0, 2'b00, 1));
        cyc(1); cyc(1);
        check("sw_addr", 16'({alu_src_a, alu_src_b, alu_operation}), 16'(9'b01_010_0010));
        cyc(1);
        check("sw_write", 16'({mem_write, iord, mem_read}), 16'(3'b110));

        // lw aborted by reset while stalled in MEM_RD
        issue(OP_LW, 6'h00, 0, 0, '0);
        cyc(1); cyc(1); cyc(0);
        check("lw_abort_state", 16'(dbg_state), 16'(ST_MEM_RD));
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_state", 16'(dbg_state), 16'(ST_FETCH));
        check("rst_mid_enables", 16'({mem_read, reg_write, instr_done}), 16'(3'b000));
        exp_q.push_back(mk(0, 8, 1, 1, 0, 0, 2'b00, 0));
        @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        check("lw_restart_fetch", 16'({dbg_state, mem_read, reg_write}), 16'({ST_FETCH, 2'b10}));
        cyc(1); cyc(1);
        for (int i = 0; i < 3; i++) begin
            cyc(0);
            check("lw_stall", 16'({mem_read, iord, reg_write}), 16'(3'b110));
        end
        cyc(1);
        check("lw_rd_done", 16'({mem_read, iord, dbg_state}), 16'({2'b11, ST_MEM_RD}));
        cyc(1);
        check("lw_wb", 16'({mem_to_reg, reg_write, reg_dst, instr_done}), 16'(4'b1101));

        // illegal opcode, then illegal R-type funct
        issue(6'h3F, 6'h00, 0, 1, mk(1, 2, 0, 0, 0, 0, 2'b00, 0));
        cyc(1);
        check("ill_op", 16'({illegal_instr, reg_write, mem_write}), 16'(3'b100));
        issue(OP_RTYPE, 6'h27, 0, 1, mk(1, 2, 0, 0, 0, 0, 2'b00, 0));
        check("ill_op_next_fetch", 16'(dbg_state), 16'(ST_FETCH));
        cyc(1);
        check("ill_fn", 16'({illegal_instr, reg_write, mem_write}), 16'(3'b100));
        cyc(0);
        check("ill_fn_next_fetch", 16'({dbg_state, illegal_instr}), 16'({ST_FETCH, 1'b0}));

        check("scoreboard_drained", 16'(exp_q.size()), 16'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
